// File: rtl/gray_pkg.sv
// Shared definitions for the gray pipeline driver: FSM encoding, mode codes,
// luma weights, status bit positions and an 8-bit saturation helper.
package gray_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } gray_state_e;

  localparam logic [1:0] MODE_AVG   = 2'd0;
  localparam logic [1:0] MODE_LUMA  = 2'd1;
  localparam logic [1:0] MODE_GREEN = 2'd2;

  localparam logic [7:0] LUMA_W_R = 8'd77;
  localparam logic [7:0] LUMA_W_G = 8'd150;
  localparam logic [7:0] LUMA_W_B = 8'd29;

  localparam int STAT_SIZE_ERR = 0;
  localparam int STAT_MODE_ERR = 1;

  function automatic logic [7:0] sat_u8(input logic [9:0] v);
    return (v > 10'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/gray_pipe_driv_if.sv
// Pixel stream bundle (valid, word address, word data) passed between the
// read side, the arithmetic pipeline and the BRAM write port.
interface gray_pipe_driv_if #(
  parameter int WD_DAT = 32
);
  logic              vld;
  logic [WD_DAT-1:0] addr;
  logic [WD_DAT-1:0] dat;

  modport master (output vld, addr, dat);
  modport slave  (input  vld, addr, dat);
endinterface

// File: rtl/gray_calc_pipe.sv
// Three-stage RGB-to-gray pipeline: field split, weighted sums, then
// mode select with saturation packed as {gray, B, G, R}.
module gray_calc_pipe
  import gray_pkg::*;
#(
  parameter int WD_DAT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_mode,
  gray_pipe_driv_if.slave        pipe_in,
  gray_pipe_driv_if.master       pipe_out
);

  logic              r_s1_vld;
  logic [WD_DAT-1:0] r_s1_addr;
  logic [23:0]       r_s1_rgb;

  logic              r_s2_vld;
  logic [WD_DAT-1:0] r_s2_addr;
  logic [23:0]       r_s2_rgb;
  logic [9:0]        r_s2_sum;
  logic [17:0]       r_s2_luma;

  logic              r_s3_vld;
  logic [WD_DAT-1:0] r_s3_addr;
  logic [WD_DAT-1:0] r_s3_dat;

  logic [7:0] w_r, w_g, w_b;
  logic [7:0] w_gray;
  logic       w_unused_hi;

  assign w_r = r_s1_rgb[7:0];
  assign w_g = r_s1_rgb[15:8];
  assign w_b = r_s1_rgb[23:16];

  // The top byte of the incoming word carries no pixel information.
  assign w_unused_hi = ^pipe_in.dat[WD_DAT-1:24];

  always_comb begin
    w_gray = r_s2_rgb[15:8];
    case (i_mode)
      MODE_AVG:  w_gray = sat_u8(r_s2_sum / 10'd3);
      MODE_LUMA: w_gray = sat_u8(r_s2_luma[17:8]);
      default:   w_gray = r_s2_rgb[15:8];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_rgb  <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_addr <= '0;
      r_s2_rgb  <= '0;
      r_s2_sum  <= '0;
      r_s2_luma <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_addr <= '0;
      r_s3_dat  <= '0;
    end else begin
      r_s1_vld  <= pipe_in.vld;
      r_s1_addr <= pipe_in.addr;
      r_s1_rgb  <= pipe_in.dat[23:0];

      r_s2_vld  <= r_s1_vld;
      r_s2_addr <= r_s1_addr;
      r_s2_rgb  <= r_s1_rgb;
      r_s2_sum  <= 10'(w_r) + 10'(w_g) + 10'(w_b);
      r_s2_luma <= 18'(LUMA_W_R) * 18'(w_r) + 18'(LUMA_W_G) * 18'(w_g)
                 + 18'(LUMA_W_B) * 18'(w_b);

      r_s3_vld  <= r_s2_vld;
      r_s3_addr <= r_s2_addr;
      r_s3_dat  <= WD_DAT'({w_gray, r_s2_rgb});
    end
  end

  assign pipe_out.vld  = r_s3_vld;
  assign pipe_out.addr = r_s3_addr;
  assign pipe_out.dat  = r_s3_dat;

endmodule

// File: rtl/gray_pipe_driv.sv
// Gray-conversion job driver: validates a shake request, streams N words out
// of BRAM through the gray pipeline and writes them back in place.
module gray_pipe_driv
  import gray_pkg::*;
#(
  parameter int WD_SHK_SYNC = 16,
  parameter int WD_SHK_DLAY = 15,
  parameter int WD_BRAM_DAT = 32,
  parameter int WD_BRAM_WEN = 4,
  parameter int WD_ERR_INFO = 4,
  parameter int WD_SIZE_MAX = 10,
  parameter int NB_RD_LAT   = 2
) (
  input  logic                   s_sys_a_clock,
  input  logic                   s_sys_a_resetn,
  input  logic                   s_shk_gray_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_gray_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_gray_dmosi,
  output logic                   s_shk_gray_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_gray_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_gray_dmiso,
  output logic [WD_BRAM_DAT-1:0] m_bram_rd_addr,
  output logic                   m_bram_rd_en,
  input  logic [WD_BRAM_DAT-1:0] m_bram_rd_dout,
  output logic [WD_BRAM_DAT-1:0] m_bram_wr_addr,
  output logic [WD_BRAM_DAT-1:0] m_bram_wr_din,
  output logic                   m_bram_wr_en,
  output logic [WD_BRAM_WEN-1:0] m_bram_wr_we,
  output logic                   m_bram_gray_clk,
  input  logic [WD_ERR_INFO-1:0] s_err_gray_info1,
  output logic [WD_ERR_INFO-1:0] m_err_gray_info1
);

  localparam int unsigned N_MAX = 2 ** WD_SIZE_MAX;

  gray_state_e            r_state;
  logic [WD_SHK_SYNC-1:0] r_num;
  logic [WD_SHK_SYNC-1:0] r_smiso;
  logic [1:0]             r_mode;
  logic                   r_size_err;
  logic                   r_mode_err;
  logic                   r_wready;
  logic                   r_rd_en;
  logic [WD_BRAM_DAT-1:0] r_rd_addr;
  logic                   r_vld_sr  [NB_RD_LAT];
  logic [WD_BRAM_DAT-1:0] r_addr_sr [NB_RD_LAT];

  logic                   w_size_bad;
  logic                   w_mode_bad;
  logic                   w_last_rd;
  logic                   w_last_wr;
  logic [WD_SHK_DLAY-1:0] w_stat;
  logic [WD_ERR_INFO-1:0] w_err_loc;
  logic                   w_unused_dmosi;

  gray_pipe_driv_if #(.WD_DAT(WD_BRAM_DAT)) w_pix_in ();
  gray_pipe_driv_if #(.WD_DAT(WD_BRAM_DAT)) w_pix_out ();

  assign w_size_bad = (s_shk_gray_smosi == '0) || (32'(s_shk_gray_smosi) > N_MAX);
  assign w_mode_bad = (s_shk_gray_dmosi[1:0] == 2'd3);
  assign w_last_rd  = (r_rd_addr + WD_BRAM_DAT'(1)) == WD_BRAM_DAT'(r_num);
  assign w_last_wr  = w_pix_out.vld && ((r_smiso + WD_SHK_SYNC'(1)) == r_num);
  assign w_unused_dmosi = ^s_shk_gray_dmosi[WD_SHK_DLAY-1:2];

  always_ff @(posedge s_sys_a_clock or negedge s_sys_a_resetn) begin
    if (!s_sys_a_resetn) begin
      r_state    <= ST_IDLE;
      r_num      <= '0;
      r_smiso    <= '0;
      r_mode     <= '0;
      r_size_err <= 1'b0;
      r_mode_err <= 1'b0;
      r_wready   <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      if (w_pix_out.vld) begin
        r_smiso <= r_smiso + WD_SHK_SYNC'(1);
      end
      unique case (r_state)
        ST_IDLE: begin
          if (s_shk_gray_wvalid) begin
            r_state    <= ST_CHECK;
            r_smiso    <= '0;
            r_size_err <= 1'b0;
            r_mode_err <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_num      <= s_shk_gray_smosi;
          r_mode     <= s_shk_gray_dmosi[1:0];
          r_size_err <= w_size_bad;
          r_mode_err <= w_mode_bad;
          if (w_size_bad || w_mode_bad) begin
            r_state  <= ST_DONE;
            r_wready <= 1'b1;
          end else begin
            r_state   <= ST_RUN;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        ST_RUN: begin
          if (w_last_rd) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + WD_BRAM_DAT'(1);
          end
        end
        ST_DRAIN: begin
          if (w_last_wr) begin
            r_state  <= ST_DONE;
            r_wready <= 1'b1;
          end
        end
        ST_DONE: begin
          // Requester drops wvalid to acknowledge; only then can a new job start.
          if (!s_shk_gray_wvalid) begin
            r_state    <= ST_IDLE;
            r_wready   <= 1'b0;
            r_size_err <= 1'b0;
            r_mode_err <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid/address follow the BRAM read latency so they line up with rd_dout.
  always_ff @(posedge s_sys_a_clock or negedge s_sys_a_resetn) begin
    if (!s_sys_a_resetn) begin
      for (int i = 0; i < NB_RD_LAT; i++) begin
        r_vld_sr[i]  <= 1'b0;
        r_addr_sr[i] <= '0;
      end
    end else begin
      r_vld_sr[0]  <= r_rd_en;
      r_addr_sr[0] <= r_rd_addr;
      for (int i = 1; i < NB_RD_LAT; i++) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_addr_sr[i] <= r_addr_sr[i-1];
      end
    end
  end

  assign w_pix_in.vld  = r_vld_sr[NB_RD_LAT-1];
  assign w_pix_in.addr = r_addr_sr[NB_RD_LAT-1];
  assign w_pix_in.dat  = m_bram_rd_dout;

  gray_calc_pipe #(
    .WD_DAT (WD_BRAM_DAT)
  ) u_calc (
    .clk      (s_sys_a_clock),
    .rst_n    (s_sys_a_resetn),
    .i_mode   (r_mode),
    .pipe_in  (w_pix_in.slave),
    .pipe_out (w_pix_out.master)
  );

  always_comb begin
    w_stat                = '0;
    w_stat[STAT_SIZE_ERR] = r_size_err;
    w_stat[STAT_MODE_ERR] = r_mode_err;
    w_err_loc                = '0;
    w_err_loc[STAT_SIZE_ERR] = r_size_err;
    w_err_loc[STAT_MODE_ERR] = r_mode_err;
  end

  assign s_shk_gray_wready = r_wready;
  assign s_shk_gray_smiso  = r_smiso;
  assign s_shk_gray_dmiso  = w_stat;
  assign m_err_gray_info1  = s_err_gray_info1 | w_err_loc;

  assign m_bram_rd_en    = r_rd_en;
  assign m_bram_rd_addr  = r_rd_addr;
  assign m_bram_wr_en    = w_pix_out.vld;
  assign m_bram_wr_addr  = w_pix_out.addr;
  assign m_bram_wr_din   = w_pix_out.dat;
  assign m_bram_wr_we    = {WD_BRAM_WEN{w_pix_out.vld}};
  assign m_bram_gray_clk = s_sys_a_clock;

endmodule

// File: tb/tb_gray_pipe_driv.sv
// Directed bench for gray_pipe_driv: BRAM model, write scoreboard checked by
// a monitor process, and per-job handshake/status checks.
module tb_gray_pipe_driv;
  import gray_pkg::*;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wvalid = 1'b0;
  logic [15:0] smosi = '0;
  logic [14:0] dmosi = '0;
  logic        wready;
  logic [15:0] smiso;
  logic [14:0] dmiso;
  logic [31:0] rd_addr;
  logic        rd_en;
  logic [31:0] rd_dout;
  logic [3:0]  wr_we;
  logic        gclk;
  logic [3:0]  s_err = '0;
  logic [3:0]  m_err;

  gray_pipe_driv_if #(.WD_DAT(32)) wr_mon ();

  always #5 clk = ~clk;

  gray_pipe_driv #(
    .WD_SHK_SYNC(16), .WD_SHK_DLAY(15), .WD_BRAM_DAT(32), .WD_BRAM_WEN(4),
    .WD_ERR_INFO(4), .WD_SIZE_MAX(10), .NB_RD_LAT(L)
  ) dut (
    .s_sys_a_clock     (clk),
    .s_sys_a_resetn    (rst_n),
    .s_shk_gray_wvalid (wvalid),
    .s_shk_gray_smosi  (smosi),
    .s_shk_gray_dmosi  (dmosi),
    .s_shk_gray_wready (wready),
    .s_shk_gray_smiso  (smiso),
    .s_shk_gray_dmiso  (dmiso),
    .m_bram_rd_addr    (rd_addr),
    .m_bram_rd_en      (rd_en),
    .m_bram_rd_dout    (rd_dout),
    .m_bram_wr_addr    (wr_mon.addr),
    .m_bram_wr_din     (wr_mon.dat),
    .m_bram_wr_en      (wr_mon.vld),
    .m_bram_wr_we      (wr_we),
    .m_bram_gray_clk   (gclk),
    .s_err_gray_info1  (s_err),
    .m_err_gray_info1  (m_err)
  );

  // BRAM read model with L-cycle latency.
  logic [31:0] mem [1024];
  logic [31:0] rd_pipe [L];
  always @(posedge clk) begin
    rd_pipe[0] <= rd_en ? mem[rd_addr[9:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_dout = rd_pipe[L-1];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
  } wr_exp_t;

  wr_exp_t sb_q[$];
  int      rd_time_q[$];
  int      n_checks = 0;
  int      n_pass = 0;
  int      cyc = 0;
  int      rd_total = 0;
  int      wr_total = 0;
  int      first_rd = -1;
  int      last_rd = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] avg_word(input logic [31:0] w);
    int s;
    s = int'(w[7:0]) + int'(w[15:8]) + int'(w[23:16]);
    return {8'(s / 3), w[23:0]};
  endfunction

  task automatic monitor();
    wr_exp_t e;
    int t;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_en) begin
        rd_total++;
        rd_time_q.push_back(cyc);
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (wr_mon.vld) begin
        wr_total++;
        if (sb_q.size() == 0) begin
          chk("wr_unexpected", {wr_mon.addr, wr_mon.dat}, 64'h0);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr_din", {wr_mon.addr, wr_mon.dat}, {e.addr, e.din});
        end
        chk("wr_we", 64'(wr_we), 64'hF);
        if (rd_time_q.size() == 0) begin
          chk("wr_without_rd", 64'd1, 64'd0);
        end else begin
          t = rd_time_q.pop_front();
          chk("rd_to_wr_latency", 64'(cyc - t), 64'(L + 3));
        end
      end
    end
  endtask

  task automatic run_job(input int n, input logic [1:0] mode, input logic [3:0] serr,
                         input bit drop_early, input logic [14:0] exp_dmiso);
    int  rd0, wr0;
    bit  done;
    bit  is_err;
    is_err = (exp_dmiso != '0);
    rd0 = rd_total;
    wr0 = wr_total;
    first_rd = -1;
    last_rd = -1;
    done = 1'b0;
    @(negedge clk);
    smosi  = 16'(n);
    dmosi  = 15'(mode);
    s_err  = serr;
    wvalid = 1'b1;
    if (drop_early) begin
      repeat (3) @(negedge clk);
      wvalid = 1'b0;
    end
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (wready) done = 1'b1;
    end
    chk("wready_reached", 64'(done), 64'd1);
    chk("smiso", 64'(smiso), is_err ? 64'd0 : 64'(n));
    chk("dmiso", 64'(dmiso), 64'(exp_dmiso));
    chk("m_err", 64'(m_err), 64'(serr | exp_dmiso[3:0]));
    chk("rd_count", 64'(rd_total - rd0), is_err ? 64'd0 : 64'(n));
    chk("wr_count", 64'(wr_total - wr0), is_err ? 64'd0 : 64'(n));
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    if (!is_err) chk("rd_span", 64'(last_rd - first_rd + 1), 64'(n));
    if (!drop_early) begin
      repeat (2) @(negedge clk);
      chk("done_holds", 64'(wready), 64'd1);
      wvalid = 1'b0;
    end
    @(negedge clk);
    chk("wready_low_after", 64'(wready), 64'd0);
    $display("job n=%0d mode=%0d drop=%0d smiso=%0d dmiso=0x%0h m_err=0x%0h",
             n, mode, drop_early, smiso, dmiso, m_err);
  endtask

  initial begin
    int k;
    wr_exp_t e;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_smiso", 64'(smiso), 64'd0);
    chk("rst_dmiso", 64'(dmiso), 64'd0);
    chk("rst_rd_wr_en", {62'd0, rd_en, wr_mon.vld}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("gray_clk", 64'(gclk), 64'(clk));

    // Single-pixel vectors with hand-computed results.
    mem[0] = 32'h0030_2010;
    e = '{addr: 32'd0, din: 32'h2030_2010}; sb_q.push_back(e);
    run_job(1, MODE_AVG, 4'b0100, 1'b0, 15'd0);
    e = '{addr: 32'd0, din: 32'h1D30_2010}; sb_q.push_back(e);
    run_job(1, MODE_LUMA, 4'b0000, 1'b0, 15'd0);
    mem[0] = 32'h00FF_FFFF;
    e = '{addr: 32'd0, din: 32'hFFFF_FFFF}; sb_q.push_back(e);
    run_job(1, MODE_LUMA, 4'b0000, 1'b0, 15'd0);

    // Green-only with a non-zero ignored top byte.
    mem[0] = 32'h0011_2233; mem[1] = 32'hFF00_AB00; mem[2] = 32'h1234_5678;
    e = '{addr: 32'd0, din: 32'h2211_2233}; sb_q.push_back(e);
    e = '{addr: 32'd1, din: 32'hAB00_AB00}; sb_q.push_back(e);
    e = '{addr: 32'd2, din: 32'h5634_5678}; sb_q.push_back(e);
    run_job(3, MODE_GREEN, 4'b0000, 1'b0, 15'd0);

    // Full-size average job.
    for (int i = 0; i < 1024; i++) begin
      mem[i] = {8'hEE, 8'(i * 5 + 1), 8'(i * 3), 8'(i)};
      e = '{addr: 32'(i), din: avg_word(mem[i])};
      sb_q.push_back(e);
    end
    run_job(1024, MODE_AVG, 4'b0000, 1'b0, 15'd0);

    // Rejected jobs: no BRAM traffic at all.
    run_job(0, MODE_AVG, 4'b1000, 1'b0, 15'b01);
    run_job(1025, MODE_AVG, 4'b0010, 1'b0, 15'b01);
    run_job(5, 2'd3, 4'b0000, 1'b0, 15'b10);

    // wvalid released mid-job: job completes, DONE lasts one cycle.
    for (int i = 0; i < 8; i++) begin
      mem[i] = {8'h00, 8'(i * 40), 8'(255 - i), 8'(i * 17)};
      e = '{addr: 32'(i), din: avg_word(mem[i])};
      sb_q.push_back(e);
    end
    run_job(8, MODE_AVG, 4'b0000, 1'b1, 15'd0);

    // Reset on the 10th write of a 100-pixel job.
    for (int i = 0; i < 100; i++) begin
      mem[i] = {8'h00, 8'(i), 8'(i + 1), 8'(i + 2)};
      e = '{addr: 32'(i), din: avg_word(mem[i])};
      sb_q.push_back(e);
    end
    @(negedge clk);
    smosi = 16'd100; dmosi = 15'(MODE_AVG); s_err = '0; wvalid = 1'b1;
    k = 0;
    for (int c = 0; c < 2000 && k < 10; c++) begin
      @(negedge clk);
      if (wr_mon.vld) k++;
    end
    chk("mid_reset_reached_10th", 64'(k), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {61'd0, rd_en, wr_mon.vld, wready}, 64'd0);
    chk("mid_rst_we", 64'(wr_we), 64'd0);
    chk("mid_rst_smiso", 64'(smiso), 64'd0);
    chk("mid_rst_dmiso", 64'(dmiso), 64'd0);
    chk("mid_rst_addr", {rd_addr, wr_mon.addr}, 64'd0);
    wvalid = 1'b0;
    sb_q.delete();
    rd_time_q.delete();
    repeat (3) @(negedge clk);
    chk("mid_rst_no_wr", 64'(wr_mon.vld), 64'd0);
    rst_n = 1'b1;
    rd_time_q.delete();
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mem[i] = {8'h00, 8'(200 + i), 8'(100 + i), 8'(50 + i)};
      e = '{addr: 32'(i), din: avg_word(mem[i])};
      sb_q.push_back(e);
    end
    run_job(4, MODE_AVG, 4'b0000, 1'b0, 15'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_pipe_driv.md
GRAY_PIPE_DRIV -- requirements
Module: gray_pipe_driv

Interface
REQ-001 SHALL have parameter WD_SHK_SYNC, default 16: shake sync-field width; carries the pixel count in and the written-pixel count out.
REQ-002 SHALL have parameter WD_SHK_DLAY, default 15: shake data-field width; carries the mode in and the status out.
REQ-003 SHALL have parameter WD_BRAM_DAT, default 32: BRAM address and data width.
REQ-004 SHALL have parameter WD_BRAM_WEN, default 4: BRAM byte-write-enable width.
REQ-005 SHALL have parameter WD_ERR_INFO, default 4: error-bus width, minimum 2.
REQ-006 SHALL have parameter WD_SIZE_MAX, default 10: maximum pixel count is 2^WD_SIZE_MAX.
REQ-007 SHALL have parameter NB_RD_LAT, default 2: BRAM read latency in cycles, range 1..4.
REQ-008 SHALL have these ports (name, direction, width, meaning):
- s_sys_a_clock, in, 1: the only clock.
- s_sys_a_resetn, in, 1: reset, asynchronous, active-low.
- s_shk_gray_wvalid, in, 1: job request, held high until done.
- s_shk_gray_smosi, in, WD_SHK_SYNC: pixel count.
- s_shk_gray_dmosi, in, WD_SHK_DLAY: bits [1:0] select the mode.
- s_shk_gray_wready, out, 1: job done.
- s_shk_gray_smiso, out, WD_SHK_SYNC: pixels written.
- s_shk_gray_dmiso, out, WD_SHK_DLAY: status; bit0 size error, bit1 mode error, other bits 0.
- m_bram_rd_addr, out, WD_BRAM_DAT: read address, in words.
- m_bram_rd_en, out, 1: read enable.
- m_bram_rd_dout, in, WD_BRAM_DAT: read data, valid NB_RD_LAT cycles after rd_en.
- m_bram_wr_addr, out, WD_BRAM_DAT: write address.
- m_bram_wr_din, out, WD_BRAM_DAT: write data.
- m_bram_wr_en, out, 1: write enable.
- m_bram_wr_we, out, WD_BRAM_WEN: byte write enables.
- m_bram_gray_clk, out, 1: equal to s_sys_a_clock.
- s_err_gray_info1, in, WD_ERR_INFO: upstream error bus.
- m_err_gray_info1, out, WD_ERR_INFO: error bus out.

Function
REQ-009 SHALL implement states IDLE, CHECK, RUN, DRAIN and DONE.
- IDLE to CHECK when wvalid is high.
- CHECK to DONE with error on a bad size or mode, otherwise to RUN.
- RUN to DRAIN after N reads have been issued.
- DRAIN to DONE when the last write is issued.
- DONE to IDLE when wvalid is low.
REQ-010 CHECK SHALL latch N = smosi and mode = dmosi[1:0], and SHALL flag a size error when N == 0 or N > 2^WD_SIZE_MAX.
REQ-011 Mode SHALL be decoded as follows; mode 3 is a mode error.
- 0: average, floor((R+G+B)/3), using a 10-bit sum.
- 1: BT.601 luma, (77R + 150G + 29B) >> 8, using an 18-bit product sum.
- 2: G only.
REQ-012 Pixel field mapping SHALL be R = word[7:0], G = word[15:8], B = word[23:16]; word[31:24] is ignored on input.
REQ-013 RUN SHALL issue one read per cycle at addresses 0..N-1, with rd_en high for exactly N consecutive cycles.
REQ-014 Arithmetic SHALL be a 3-stage pipeline; a read issued at cycle t SHALL produce wr_en at t + NB_RD_LAT + 3, at the same address.
REQ-015 Write data SHALL be {gray[7:0], R, G, B bits [23:0] unchanged}; wr_we SHALL be all ones while wr_en is high and 0 otherwise.
REQ-016 Throughput SHALL be one pixel per cycle with no bubbles, and writes SHALL be issued in address order.
REQ-017 The gray result SHALL saturate at 255; in luma mode, white (0xFFFFFF) SHALL give 255.
REQ-018 smiso SHALL count wr_en pulses, SHALL clear on entering CHECK, and SHALL hold through DONE.
REQ-019 wready SHALL be high only in DONE; dmiso and the local error bits SHALL be valid while wready is high.
REQ-020 m_err_gray_info1 SHALL equal s_err_gray_info1 with bit0 ORed with the size error and bit1 ORed with the mode error.
REQ-021 A job that errors SHALL issue no BRAM reads or writes.
REQ-022 If wvalid drops mid-job, the job SHALL still complete; DONE then returns to IDLE on the next cycle.
REQ-023 A new job SHALL NOT start until DONE has been left.

Reset
REQ-024 Assertion of s_sys_a_resetn (low) SHALL asynchronously clear to 0 the state, counters, pipeline valid bits, rd_en, wr_en, wr_we, addresses, wready, smiso and dmiso.
REQ-025 Reset mid-job SHALL abort the job with no further writes; the BRAM contents written so far are undefined.

Structure
REQ-026 A shared package gray_pkg SHALL hold:
- the state encoding;
- the mode codes MODE_AVG = 0, MODE_LUMA = 1, MODE_GREEN = 2;
- the luma weights 77, 150 and 29;
- the status bit indices.
REQ-027 The arithmetic SHALL be a sub-module gray_calc_pipe (3 stages, valid in/out), instantiated once.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Mode 0, N = 1, word 0x00302010: wr_din = 0x20302010 at address 0; smiso = 1; wready high.
- Mode 1, same word: wr_din = 0x1D302010; mode 1, word 0x00FFFFFF: wr_din = 0xFFFFFFFF.
- Mode 0, N = 1024: 1024 back-to-back writes at addresses 0..1023; rd_en-to-wr_en latency = NB_RD_LAT + 3; smiso = 1024.
- N = 0, and separately N = 1025: no rd_en or wr_en; dmiso bit0 = 1; m_err_gray_info1 bit0 = 1.
- Mode 3: no BRAM access; dmiso bit1 = 1.
- Reset asserted at the 10th write of an N = 100 job: outputs are 0 immediately; after release, the next job (N = 4) completes normally with smiso = 4.
